// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns stores into byte-enabled word requests, extends load data,
// and stalls the pipeline while a req/ack memory access is outstanding.
module load_store_unit #(
  parameter int unsigned Timeout = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        ex_valid_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_write_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_reg_write_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            wb_rw_q, wb_rw_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  // Request decode from the EX/MEM register
  logic        is_byte, is_half, is_mem, misaligned;
  logic [31:0] wdata_rep;
  logic [3:0]  be_dec;

  always_comb begin
    is_byte    = (ex_funct3_i[1:0] == 2'b00);
    is_half    = (ex_funct3_i[1:0] == 2'b01);
    is_mem     = ex_mem_read_i | ex_mem_write_i;
    misaligned = (is_half & ex_addr_i[0]) | (!is_byte & !is_half & (ex_addr_i[1:0] != 2'b00));
    if (is_byte) begin
      wdata_rep = {4{ex_wdata_i[7:0]}};
      be_dec    = 4'b0001 << ex_addr_i[1:0];
    end else if (is_half) begin
      wdata_rep = {2{ex_wdata_i[15:0]}};
      be_dec    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
    end else begin
      wdata_rep = ex_wdata_i;
      be_dec    = 4'b1111;
    end
  end

  // Load lane selection and extension, using the captured size and offset
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_rw_d    = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_i;
            wb_data_d  = ex_addr_i;
            wb_rw_d    = ex_reg_write_i;
          end else if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_mem_write_i;
            addr_d  = {ex_addr_i[31:2], 2'b00};
            wdata_d = wdata_rep;
            be_d    = be_dec;
            f3_d    = ex_funct3_i;
            off_d   = ex_addr_i[1:0];
            rd_d    = ex_rd_i;
            rw_d    = ex_reg_write_i;
          end
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          state_d    = StIdle;
          cnt_d      = '0;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = we_q ? 32'b0 : ld_ext;
          wb_rw_d    = rw_q & !we_q;
        end else if (cnt_q == CntW'(Timeout - 1)) begin
          state_d   = StIdle;
          cnt_d     = '0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_rw_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_rw_q    <= wb_rw_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_req_o      = req_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_be_o       = be_q;
  assign stall_o        = (state_q == StBusy);
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign wb_reg_write_o = wb_rw_q;
  assign misalign_o     = misalign_q;
  assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed instructions push expected writeback, memory
// request and stall-length records; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall, wb_valid, wb_reg_write, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  load_store_unit #(.Timeout(16)) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_mem_write_i(ex_mem_write),
    .ex_funct3_i   (ex_funct3),
    .ex_addr_i     (ex_addr),
    .ex_wdata_i    (ex_wdata),
    .ex_rd_i       (ex_rd),
    .ex_reg_write_i(ex_reg_write),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_be_o      (mem_be),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .stall_o       (stall),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .wb_reg_write_o(wb_reg_write),
    .misalign_o    (misalign),
    .bus_err_o     (bus_err)
  );

  // kind = {wb_valid, misalign, bus_err}
  typedef struct {logic [2:0] kind; logic [4:0] rd; logic [31:0] data; logic rw;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; bit full;} mem_t;
  typedef struct {int delay; logic [31:0] rdata;} resp_t;

  wb_t   wb_q[$];
  mem_t  mem_q[$];
  int    stall_q[$];
  resp_t resp_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_reset = 1'b0;
  logic chk_end = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] data,
                        input logic rw);
    wb_q.push_back('{kind, rd, data, rw});
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit full);
    mem_q.push_back('{we, addr, wdata, be, full});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // delay = ack on the delay-th cycle after mem_req is first seen; 0 = no memory access
  task automatic issue(input logic rdop, input logic wrop, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic rw, input int delay, input logic [31:0] rdata);
    int guard = 0;
    while (stall) begin
      tick(1);
      guard++;
      if (guard > 64) begin
        $display("FAIL issue_wait stall actual=1 required=0");
        $fatal(1, "stall never released");
      end
    end
    if (delay > 0) resp_q.push_back('{delay, rdata});
    ex_valid     = 1'b1;
    ex_mem_read  = rdop;
    ex_mem_write = wrop;
    ex_funct3    = f3;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_rd        = rd;
    ex_reg_write = rw;
    tick(1);
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  // Memory responder
  initial begin
    int    n = 0;
    bit    active = 0;
    resp_t r;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!active && mem_req === 1'b1) begin
        r      = (resp_q.size() > 0) ? resp_q.pop_front() : '{1, 32'h0};
        n      = 1;
        active = 1;
      end else if (active) begin
        n++;
      end
      if (active && n == r.delay) begin
        mem_ack   = 1'b1;
        mem_rdata = r.rdata;
        active    = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_req = 1'b0;
    int   run = 0;
    wb_t  w;
    mem_t m;
    forever begin
      @(negedge clk);
      if (chk_reset) begin
        chk("reset_ctl", {17'b0, mem_req, mem_we, mem_be, stall, wb_valid, wb_reg_write,
                          misalign, bus_err, wb_rd}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_wb_data", wb_data, 32'h0);
      end
      if (rst_n === 1'b1) begin
        if (mem_req === 1'b1) begin
          chk("mem_req_expected", {31'b0, mem_q.size() != 0}, 32'h1);
          if (mem_q.size() != 0) begin
            m = mem_q[0];
            chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            if (m.full) begin
              chk("mem_wdata", mem_wdata, m.wdata);
              chk("mem_be", {28'b0, mem_be}, {28'b0, m.be});
            end
          end
        end
        if ((wb_valid | misalign | bus_err) === 1'b1) begin
          chk("wb_event_expected", {31'b0, wb_q.size() != 0}, 32'h1);
          if (wb_q.size() != 0) begin
            w = wb_q.pop_front();
            chk("wb_kind", {29'b0, wb_valid, misalign, bus_err}, {29'b0, w.kind});
            chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, w.rw});
            if (w.kind[2]) begin
              chk("wb_rd", {27'b0, wb_rd}, {27'b0, w.rd});
              chk("wb_data", wb_data, w.data);
            end
          end
        end
      end
      if (prev_req === 1'b1 && mem_req === 1'b0 && mem_q.size() != 0) void'(mem_q.pop_front());
      prev_req = mem_req;
      if (stall === 1'b1) begin
        run++;
      end else if (run > 0) begin
        chk("stall_run_expected", {31'b0, stall_q.size() != 0}, 32'h1);
        if (stall_q.size() != 0) chk("stall_cycles", run, stall_q.pop_front());
        run = 0;
      end
      if (chk_end) begin
        chk("wb_queue_drained", wb_q.size(), 32'h0);
        chk("mem_queue_drained", mem_q.size(), 32'h0);
        chk("stall_queue_drained", stall_q.size(), 32'h0);
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    tick(2);
    rst_n = 1'b1; chk_reset = 1'b1;
    tick(1);
    chk_reset = 1'b0;

    // ADD retires next cycle with the ALU result
    exp_wb(3'b100, 5'd3, 32'h1234_5678, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    tick(1);

    // Reset while a LW request is pending; its ack arrives late and must be ignored
    exp_mem(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    stall_q.push_back(2);
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd2, 1'b1, 4, 32'h5555_5555);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; chk_reset = 1'b1;
    tick(1);
    chk_reset = 1'b0;
    tick(3);

    // SW, ack on third request cycle; reg_write forced low
    exp_mem(1'b1, 32'h08, 32'h1122_3344, 4'b1111, 1'b1);
    stall_q.push_back(3);
    exp_wb(3'b100, 5'd5, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'h08, 32'h1122_3344, 5'd5, 1'b1, 3, 32'h0);

    // LB / LBU lane 1 of 0x00008000, back to back
    exp_mem(1'b0, 32'h04, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd7, 32'hFFFF_FF80, 1'b1);
    issue(1'b1, 1'b0, 3'b000, 32'h05, 32'h0, 5'd7, 1'b1, 1, 32'h0000_8000);
    exp_mem(1'b0, 32'h04, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd8, 32'h0000_0080, 1'b1);
    issue(1'b1, 1'b0, 3'b100, 32'h05, 32'h0, 5'd8, 1'b1, 1, 32'h0000_8000);

    // LH / LHU upper half, LW with reg_write low
    exp_mem(1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd10, 32'hFFFF_8001, 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h02, 32'h0, 5'd10, 1'b1, 1, 32'h8001_0000);
    exp_mem(1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd11, 32'h0000_8001, 1'b1);
    issue(1'b1, 1'b0, 3'b101, 32'h02, 32'h0, 5'd11, 1'b1, 1, 32'h8001_0000);
    exp_mem(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(2);
    exp_wb(3'b100, 5'd4, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, 5'd4, 1'b0, 2, 32'hDEAD_BEEF);

    // SH upper half, SB lane 3
    exp_mem(1'b1, 32'h04, 32'hABCD_ABCD, 4'b1100, 1'b1);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h06, 32'h0000_ABCD, 5'd0, 1'b0, 1, 32'h0);
    exp_mem(1'b1, 32'h00, 32'hA5A5_A5A5, 4'b1000, 1'b1);
    stall_q.push_back(1);
    exp_wb(3'b100, 5'd6, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h03, 32'h1234_56A5, 5'd6, 1'b1, 1, 32'h0);

    // Misaligned LW and SH are dropped; the following ADD still retires
    exp_wb(3'b010, 5'd0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 5'd12, 1'b1, 0, 32'h0);
    exp_wb(3'b100, 5'd9, 32'hCAFE_F00D, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    exp_wb(3'b010, 5'd0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFF, 5'd13, 1'b1, 0, 32'h0);
    tick(1);

    // LW never acked: bus error after 16 busy cycles, late ack ignored
    exp_mem(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    stall_q.push_back(16);
    exp_wb(3'b001, 5'd0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd14, 1'b1, 19, 32'h7777_7777);
    tick(24);

    exp_wb(3'b100, 5'd1, 32'h0000_0042, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h42, 32'h0, 5'd1, 1'b1, 0, 32'h0);
    tick(3);

    chk_end = 1'b1;
    tick(1);
    chk_end = 1'b0;
    tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
